// File: rtl/mcu_sequencer.sv
// mcu_sequencer: host instruction FIFO in front of the mcu compute block.
// Pops instructions into registered mcu drive lines, captures op-7 read
// results into a backpressured result port and parks on mcu opcode errors
// until the host clears them.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | NOP on the mcu lines; pops when run_en and FIFO non-empty
// S_ISSUE  | an instruction is on the mcu lines for exactly this cycle
// S_RESULT | read result held on res_*; waits for res_ready, no pops
// S_ERR    | mcu flagged a bad opcode; NOP, no pops, waits for err_clr
module mcu_sequencer #(
    parameter int op_sz  = 32,
    parameter int mem_sz = 10,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [mem_sz-1:0] in_op0,
    input  logic [op_sz-1:0]  in_op1,
    input  logic [mem_sz-1:0] in_op2,
    input  logic              run_en,
    output logic [3:0]        mcu_op,
    output logic [mem_sz-1:0] mcu_op0,
    output logic [op_sz-1:0]  mcu_op1,
    output logic [mem_sz-1:0] mcu_op2,
    input  logic [op_sz-1:0]  mcu_out,
    input  logic              mcu_op_err,
    output logic              res_valid,
    output logic [op_sz-1:0]  res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              err,
    output logic [3:0]        err_op,
    input  logic              err_clr,
    output logic [15:0]       issue_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0]    OP_READ  = 4'd7;
    localparam logic [3:0]    OP_LAST_ALU = 4'd6;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESULT, S_ERR} state_t;

    typedef struct packed {
        logic [3:0]        op;
        logic [mem_sz-1:0] op0;
        logic [op_sz-1:0]  op1;
        logic [mem_sz-1:0] op2;
    } instr_t;

    state_t            r_state;
    state_t            w_state_nxt;

    instr_t            r_fifo [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic [3:0]        r_mcu_op;
    logic [mem_sz-1:0] r_mcu_op0;
    logic [op_sz-1:0]  r_mcu_op1;
    logic [mem_sz-1:0] r_mcu_op2;
    logic              r_res_valid;
    logic [op_sz-1:0]  r_res_data;
    logic              r_err;
    logic [3:0]        r_err_op;
    logic [15:0]       r_issue_cnt;

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_nop;
    logic              w_cap;
    logic              w_inc;
    logic              w_set_err;
    logic              w_clr_err;
    logic              w_res_clr;
    instr_t            w_head;
    logic [op_sz-1:0]  w_fwd_op1;

    assign w_empty   = (r_count == '0);
    assign in_ready  = (r_count < CNT_FULL);
    assign w_push    = in_valid & in_ready;
    assign w_head    = r_fifo[r_rd_ptr];
    // ALU ops take a memory address in op1, so stale upper bits are dropped
    assign w_fwd_op1 = (w_head.op <= OP_LAST_ALU)
                       ? {{(op_sz-mem_sz){1'b0}}, w_head.op1[mem_sz-1:0]}
                       : w_head.op1;

    assign mcu_op    = r_mcu_op;
    assign mcu_op0   = r_mcu_op0;
    assign mcu_op1   = r_mcu_op1;
    assign mcu_op2   = r_mcu_op2;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign err       = r_err;
    assign err_op    = r_err_op;
    assign issue_cnt = r_issue_cnt;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    // FIFO storage: written on accepted pushes only
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{op: in_op, op0: in_op0, op1: in_op1, op2: in_op2};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and per-cycle action strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_nop       = 1'b0;
        w_cap       = 1'b0;
        w_inc       = 1'b0;
        w_set_err   = 1'b0;
        w_clr_err   = 1'b0;
        w_res_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run_en && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_nop = 1'b1;
                end
            end
            S_ISSUE: begin
                if (mcu_op_err) begin
                    w_set_err   = 1'b1;
                    w_nop       = 1'b1;
                    w_state_nxt = S_ERR;
                end else if (r_mcu_op == OP_READ) begin
                    w_cap       = 1'b1;
                    w_inc       = 1'b1;
                    w_nop       = 1'b1;
                    w_state_nxt = S_RESULT;
                end else begin
                    w_inc = 1'b1;
                    if (run_en && !w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_nop       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RESULT: begin
                w_nop = 1'b1;
                // res_valid is always set while in S_RESULT
                if (res_ready) begin
                    w_res_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_nop = 1'b1;
                if (err_clr) begin
                    w_clr_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_nop       = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered mcu drive: load on pop, otherwise park on NOP when asked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcu_op  <= OP_READ;
            r_mcu_op0 <= '0;
            r_mcu_op1 <= '0;
            r_mcu_op2 <= '0;
        end else if (w_pop) begin
            r_mcu_op  <= w_head.op;
            r_mcu_op0 <= w_head.op0;
            r_mcu_op1 <= w_fwd_op1;
            r_mcu_op2 <= w_head.op2;
        end else if (w_nop) begin
            r_mcu_op  <= OP_READ;
            r_mcu_op0 <= '0;
            r_mcu_op1 <= '0;
            r_mcu_op2 <= '0;
        end
    end

    // Read-result capture and handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else if (w_cap) begin
            r_res_valid <= 1'b1;
            r_res_data  <= mcu_out;
        end else if (w_res_clr) begin
            r_res_valid <= 1'b0;
        end
    end

    // Sticky error flag with the offending opcode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err    <= 1'b0;
            r_err_op <= '0;
        end else if (w_set_err) begin
            r_err    <= 1'b1;
            r_err_op <= r_mcu_op;
        end else if (w_clr_err) begin
            r_err    <= 1'b0;
            r_err_op <= '0;
        end
    end

    // Count of successfully issued instructions, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_issue_cnt <= '0;
        else if (w_inc) r_issue_cnt <= r_issue_cnt + 16'd1;
    end

endmodule

// File: tb/tb_mcu_sequencer.sv
// Bench for mcu_sequencer: a stand-in mcu memory/ALU, a transaction-level
// reference (pending-instruction queue, expected-result queue, reference
// memory) and directed plus randomized stimulus.
module tb_mcu_sequencer;
    localparam int OPW   = 32;
    localparam int MW    = 10;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_op;
    logic [MW-1:0]  in_op0;
    logic [OPW-1:0] in_op1;
    logic [MW-1:0]  in_op2;
    logic           run_en;
    logic [3:0]     mcu_op;
    logic [MW-1:0]  mcu_op0;
    logic [OPW-1:0] mcu_op1;
    logic [MW-1:0]  mcu_op2;
    logic [OPW-1:0] mcu_out;
    logic           mcu_op_err;
    logic           res_valid;
    logic [OPW-1:0] res_data;
    logic           res_ready;
    logic           busy;
    logic           err;
    logic [3:0]     err_op;
    logic           err_clr;
    logic [15:0]    issue_cnt;

    mcu_sequencer #(.op_sz(OPW), .mem_sz(MW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_op0(in_op0), .in_op1(in_op1), .in_op2(in_op2),
        .run_en(run_en),
        .mcu_op(mcu_op), .mcu_op0(mcu_op0), .mcu_op1(mcu_op1), .mcu_op2(mcu_op2),
        .mcu_out(mcu_out), .mcu_op_err(mcu_op_err),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .err(err), .err_op(err_op), .err_clr(err_clr),
        .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        case (op)
            4'd0:    alu = a + b;
            4'd1:    alu = a - b;
            4'd2:    alu = a & b;
            4'd3:    alu = a | b;
            4'd4:    alu = a ^ b;
            4'd5:    alu = a * b;
            default: alu = a >> b[4:0];
        endcase
    endfunction

    // Stand-in mcu: combinational read port, writes at the end of the op cycle
    logic [OPW-1:0] env_mem [1024];
    logic           env_init;
    assign mcu_out    = env_mem[mcu_op0];
    assign mcu_op_err = (mcu_op > 4'd8);
    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= '0;
        end else if (mcu_op <= 4'd6) begin
            env_mem[mcu_op2] <= alu(mcu_op, env_mem[mcu_op0], env_mem[mcu_op1[MW-1:0]]);
        end else if (mcu_op == 4'd8) begin
            env_mem[mcu_op0] <= mcu_op1;
        end
    end

    typedef struct packed {
        logic [3:0]  op;
        logic [9:0]  a;
        logic [31:0] b;
        logic [9:0]  c;
    } ins_t;

    ins_t        exp_q[$];
    logic [31:0] res_q[$];
    logic [31:0] ref_mem [1024];
    ins_t        cur;
    bit          cur_on;
    bit          m_err;
    logic [3:0]  m_err_op;
    logic [15:0] m_cnt;
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] fwd_b(input ins_t x);
        return (x.op <= 4'd6) ? {22'd0, x.b[9:0]} : x.b;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        res_q.delete();
        cur      = '0;
        cur_on   = 0;
        m_err    = 0;
        m_err_op = '0;
        m_cnt    = '0;
    endtask

    // Compare every output against what the reference says should be visible now
    task automatic model_check();
        bit idle;
        idle = !cur_on && !m_err && (res_q.size() == 0);
        chk("mcu_op",    64'(mcu_op),  64'(cur_on ? cur.op : 4'd7));
        chk("mcu_op0",   64'(mcu_op0), 64'(cur_on ? cur.a : '0));
        chk("mcu_op1",   64'(mcu_op1), 64'(cur_on ? fwd_b(cur) : '0));
        chk("mcu_op2",   64'(mcu_op2), 64'(cur_on ? cur.c : '0));
        chk("in_ready",  64'(in_ready), 64'(exp_q.size() < DEPTH));
        chk("busy",      64'(busy), 64'(!idle || exp_q.size() != 0));
        chk("err",       64'(err), 64'(m_err));
        chk("err_op",    64'(err_op), 64'(m_err ? m_err_op : 4'd0));
        chk("issue_cnt", 64'(issue_cnt), 64'(m_cnt));
        chk("res_valid", 64'(res_valid), 64'(res_q.size() != 0));
        if (res_q.size() != 0) chk("res_data", 64'(res_data), 64'(res_q[0]));
    endtask

    // Advance the reference across the coming clock edge using the driven inputs
    task automatic model_update();
        int   sz0;
        bit   rq0;
        bit   free_slot;
        ins_t nw;
        sz0 = exp_q.size();
        rq0 = (res_q.size() != 0);
        free_slot = cur_on ? (cur.op <= 4'd6 || cur.op == 4'd8) : (!m_err && !rq0);
        if (rq0 && res_ready) void'(res_q.pop_front());
        if (m_err && err_clr) begin
            m_err    = 0;
            m_err_op = '0;
        end
        if (cur_on) begin
            if (cur.op > 4'd8) begin
                m_err    = 1;
                m_err_op = cur.op;
            end else begin
                m_cnt = m_cnt + 16'd1;
                if (cur.op <= 4'd6)
                    ref_mem[cur.c] = alu(cur.op, ref_mem[cur.a], ref_mem[cur.b[9:0]]);
                else if (cur.op == 4'd8)
                    ref_mem[cur.a] = cur.b;
                else
                    res_q.push_back(ref_mem[cur.a]);
            end
        end
        cur_on = 0;
        if (run_en && free_slot && sz0 > 0) begin
            cur    = exp_q.pop_front();
            cur_on = 1;
        end
        if (in_valid && sz0 < DEPTH) begin
            nw = '{op: in_op, a: in_op0, b: in_op1, c: in_op2};
            exp_q.push_back(nw);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic push(input logic [3:0] op, input logic [9:0] a, input logic [31:0] b,
                        input logic [9:0] c);
        int g = 0;
        while (!in_ready && g < 200) begin
            tick();
            g++;
        end
        chk("push_room", 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_op    = op;
        in_op0   = a;
        in_op1   = b;
        in_op2   = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_res();
        int g = 0;
        while (!res_valid && g < 100) begin
            tick();
            g++;
        end
        chk("res_wait", 64'(res_valid), 64'(1));
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy || err) && g < 400) begin
            tick();
            g++;
        end
        chk("idle_wait", 64'(busy), 64'(0));
    endtask

    initial begin
        reset    = 1'b1;
        env_init = 1'b1;
        in_valid = 1'b0;
        in_op    = '0;
        in_op0   = '0;
        in_op1   = '0;
        in_op2   = '0;
        run_en   = 1'b0;
        res_ready = 1'b0;
        err_clr  = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        env_init = 1'b0;
        reset    = 1'b0;
        model_check();
        chk("rst_res_data", 64'(res_data), 64'(0));

        // Load, add, read
        run_en = 1'b1;
        push(4'd8, 10'd5, 32'h1234, 10'd0);
        push(4'd8, 10'd6, 32'h10, 10'd0);
        push(4'd0, 10'd5, 32'd6, 10'd7);
        push(4'd7, 10'd7, 32'd0, 10'd0);
        wait_res();
        chk("t1_res", 64'(res_data), 64'h1244);
        repeat (3) tick();
        chk("t1_hold", 64'(res_valid), 64'(1));
        chk("t1_cnt", 64'(issue_cnt), 64'(4));
        res_ready = 1'b1;
        tick();

        // Back-to-back issue
        run_en = 1'b0;
        push(4'd8, 10'd20, 32'h111, 10'd0);
        push(4'd8, 10'd21, 32'h222, 10'd0);
        push(4'd8, 10'd22, 32'h333, 10'd0);
        run_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_op", 64'(mcu_op), (k < 3) ? 64'(8) : 64'(7));
        end
        chk("t2_busy", 64'(busy), 64'(0));

        // FIFO full
        run_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(4'd8, 10'(30 + i), 32'(i + 1), 10'd0);
        chk("t3_full", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        in_op = 4'd8; in_op0 = 10'd99; in_op1 = 32'hDEAD; in_op2 = 10'd0;
        tick();
        in_valid = 1'b0;
        chk("t3_9th", 64'(in_ready), 64'(0));
        run_en = 1'b1;
        tick();
        chk("t3_ready", 64'(in_ready), 64'(1));
        wait_idle();

        // Opcode error
        run_en = 1'b0;
        push(4'd9, 10'd1, 32'd2, 10'd3);
        push(4'd8, 10'd3, 32'hAA, 10'd0);
        run_en = 1'b1;
        tick();
        tick();
        chk("t4_err", 64'(err), 64'(1));
        chk("t4_err_op", 64'(err_op), 64'(9));
        repeat (4) tick();
        chk("t4_cnt", 64'(issue_cnt), 64'(4 + 3 + DEPTH));
        chk("t4_park", 64'(mcu_op), 64'(7));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        res_ready = 1'b0;
        push(4'd7, 10'd3, 32'd0, 10'd0);
        wait_res();
        chk("t4_read", 64'(res_data), 64'hAA);
        res_ready = 1'b1;
        wait_idle();

        // Result backpressure
        res_ready = 1'b0;
        push(4'd7, 10'd20, 32'd0, 10'd0);
        push(4'd8, 10'd40, 32'h55, 10'd0);
        push(4'd4, 10'd40, 32'd20, 10'd41);
        wait_res();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_valid", 64'(res_valid), 64'(1));
            chk("t5_data", 64'(res_data), 64'h111);
        end
        res_ready = 1'b1;
        wait_idle();
        res_ready = 1'b0;
        push(4'd7, 10'd41, 32'd0, 10'd0);
        wait_res();
        chk("t5_xor", 64'(res_data), 64'h144);
        res_ready = 1'b1;
        tick();

        // Reset mid-RESULT
        res_ready = 1'b0;
        push(4'd7, 10'd5, 32'd0, 10'd0);
        wait_res();
        push(4'd8, 10'd50, 32'd1, 10'd0);
        push(4'd8, 10'd51, 32'd2, 10'd0);
        push(4'd8, 10'd52, 32'd3, 10'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6_op", 64'(mcu_op), 64'(7));
        chk("t6_op0", 64'(mcu_op0), 64'(0));
        chk("t6_op1", 64'(mcu_op1), 64'(0));
        chk("t6_op2", 64'(mcu_op2), 64'(0));
        chk("t6_res_valid", 64'(res_valid), 64'(0));
        chk("t6_res_data", 64'(res_data), 64'(0));
        chk("t6_busy", 64'(busy), 64'(0));
        chk("t6_err", 64'(err), 64'(0));
        chk("t6_cnt", 64'(issue_cnt), 64'(0));
        chk("t6_ready", 64'(in_ready), 64'(1));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        model_check();
        run_en = 1'b1;
        res_ready = 1'b1;
        repeat (5) tick();
        chk("t6_quiet", 64'(busy), 64'(0));
        push(4'd8, 10'd60, 32'h77, 10'd0);
        tick();
        chk("t6_issue", 64'(mcu_op), 64'(8));
        wait_idle();

        // Randomized traffic against the reference
        for (int n = 0; n < 2000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            in_valid = 1'($urandom_range(0, 1));
            if (r < 5)       in_op = 4'($urandom_range(9, 15));
            else if (r < 25) in_op = 4'd7;
            else if (r < 50) in_op = 4'd8;
            else             in_op = 4'($urandom_range(0, 6));
            in_op0 = 10'($urandom_range(0, 63));
            in_op1 = {22'($urandom()), 10'($urandom_range(0, 63))};
            in_op2 = 10'($urandom_range(0, 63));
            run_en    = ($urandom_range(0, 9) < 8);
            res_ready = 1'($urandom_range(0, 1));
            err_clr   = ($urandom_range(0, 4) == 0);
            tick();
        end
        in_valid  = 1'b0;
        run_en    = 1'b1;
        res_ready = 1'b1;
        err_clr   = 1'b1;
        wait_idle();
        err_clr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mcu_sequencer.md
# mcu_sequencer

- Instruction sequencer in front of the `mcu` compute block.
- Accepts instructions from a host through a valid/ready port into a DEPTH-entry FIFO.
- Issues them to the `mcu` one per cycle on registered `op`/`op0`/`op1`/`op2` lines.
- Captures read results (op 7) into a backpressured result port, and halts on `mcu` opcode errors until the host clears them.

## Interface
- `op_sz`, 32, data width; matches `mcu`.
- `mem_sz`, 10, address width; matches `mcu`.
- `DEPTH`, 8, instruction FIFO depth; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  host instruction valid.
- `in_ready`  out  1  FIFO can accept: count < DEPTH.
- `in_op`  in  4  opcode.
- `in_op0`  in  mem_sz  source-A address / load destination.
- `in_op1`  in  op_sz  source-B address (ops 0–6) or immediate (op 8).
- `in_op2`  in  mem_sz  destination address.
- `run_en`  in  1  permits new FIFO pops.
- `mcu_op`, `mcu_op0`, `mcu_op1`, `mcu_op2`  out  4 / mem_sz / op_sz / mem_sz  registered drive to `mcu`.
- `mcu_out`  in  op_sz  `mcu` out.
- `mcu_op_err`  in  1  `mcu` op_err.
- `res_valid`  out  1  read result available.
- `res_data`  out  op_sz  captured read result.
- `res_ready`  in  1  host accepts result.
- `busy`  out  1  state ≠ IDLE or FIFO non-empty.
- `err`  out  1  sticky error flag.
- `err_op`  out  4  opcode that caused the error.
- `err_clr`  in  1  clears error state.
- `issue_cnt`  out  16  count of instructions successfully issued.

## Operation
**FIFO**
- Push on `in_valid & in_ready`; `in_ready` depends on count only.
- A push and pop on the same edge are both performed.
- When full, push is blocked even if a pop occurs that edge.
- A pop needs the FIFO to be non-empty before the edge; a word pushed on edge E is poppable at E+1 at the earliest.

**Field forwarding on pop**
- Ops 0–6: `mcu_op1 = {0, in_op1[mem_sz-1:0]}`, i.e. upper bits zeroed.
- All other ops: `in_op1` is passed unchanged.

**NOP drive**
- `mcu_op = 7`, `mcu_op0 = mcu_op1 = mcu_op2 = 0`.
- Op 7 never writes memory.

**FSM states: IDLE, ISSUE, RESULT, ERR**
- **IDLE**
  - Drives NOP.
  - If `run_en` and the FIFO is non-empty: pop, load the `mcu_*` registers, go to ISSUE.
- **ISSUE** (instruction presented for exactly one cycle). The end of cycle is evaluated in priority order:
  1. `mcu_op_err = 1`: set `err`, `err_op <= mcu_op`, drive NOP, go to ERR; `issue_cnt` is unchanged.
  2. Else `mcu_op = 7`:
     - `res_data <= mcu_out` (`mcu` out is combinational from mem[op0] this cycle);
     - `res_valid <= 1`;
     - increment `issue_cnt`;
     - drive NOP, go to RESULT.
  3. Else: increment `issue_cnt`. If `run_en` and the FIFO is non-empty, pop the next instruction and stay in ISSUE (back-to-back). Otherwise drive NOP and go to IDLE.
- **RESULT**
  - Holds `res_valid` / `res_data` stable and performs no pops.
  - On `res_valid & res_ready`: clear `res_valid`, go to IDLE.
- **ERR**
  - Drives NOP with no pops; the FIFO keeps its contents and pushes are still allowed.
  - On `err_clr`: clear `err` and `err_op`, go to IDLE. The offending instruction is discarded.

**Other rules**
- `run_en = 0` only blocks pops; an in-flight ISSUE or RESULT completes normally.
- `issue_cnt` wraps 0xFFFF → 0x0000.
- Divide-by-zero and out-of-range addresses are not detected.
- Asynchronous reset mid-operation:
  - the FIFO is emptied and the FSM goes to IDLE;
  - all outputs take their reset values immediately;
  - `mcu` memory is untouched.

## Timing
- Reset values:
  - `in_ready = 1`
  - `mcu_op = 7`, `mcu_op0 = mcu_op1 = mcu_op2 = 0`
  - `res_valid = 0`, `res_data = 0`
  - `busy = 0`, `err = 0`, `err_op = 0`
  - `issue_cnt = 0`
- Latency from FIFO empty/IDLE:
  - push at edge E;
  - pop at E+1;
  - presented to `mcu` during cycle E+1→E+2;
  - `mcu` commits the write at E+2.
- Read result: `res_valid` rises at the edge ending the ISSUE cycle; earliest acceptance is one cycle later.
- Throughput:
  - ops 0–6 and 8: one per cycle back-to-back;
  - op 7: at least 2 cycles (ISSUE + RESULT) plus 1 IDLE cycle before the next pop.
- A read-after-write is naturally ordered: the write commits at the edge that ends its ISSUE cycle, before the read is presented.
- `err_clr` asserted outside ERR has no effect.

## Test plan
1. **Load, add, read**
   - Stimulus:
     - op8 `op0=5 op1=0x1234`
     - op8 `op0=6 op1=0x10`
     - op0 `op0=5 op1=6 op2=7`
     - op7 `op0=7`
   - Required: `res_data = 0x1244`, `res_valid` held until `res_ready`; `issue_cnt = 4`.
2. **Back-to-back issue**
   - Stimulus: with `run_en = 0`, push three op8 loads; then raise `run_en`.
   - Required: `mcu_op = 8` on three consecutive cycles, then 7; `busy` falls the cycle after the last.
3. **FIFO full**
   - Stimulus: with `run_en = 0`, push 8 entries.
   - Required: `in_ready = 0` after the 8th; a 9th `in_valid` is not taken. Raising `run_en` pops and `in_ready` returns to 1.
4. **Opcode error**
   - Stimulus: push op9 followed by op8 `op0=3 op1=0xAA`.
   - Required:
     - `err = 1`, `err_op = 9`; no pop while in ERR; `issue_cnt` unchanged.
     - After `err_clr`, the op8 issues, then `mem[3]` read via op7 returns 0xAA.
5. **Result backpressure**
   - Stimulus: hold `res_ready = 0` for 5 cycles with 2 more instructions queued.
   - Required: `res_valid` and `res_data` stable and zero pops; after acceptance, queued instructions issue.
6. **Reset mid-RESULT**
   - Stimulus: assert `reset` with `res_valid = 1` and 3 entries queued.
   - Required: all outputs at reset values asynchronously; after release, nothing issues until new pushes.
